// File: rtl/alu_iter.sv
// Iterative ALU: registers operands, finishes single-cycle ops in one cycle and shifts one bit per cycle.
// Define ALU_FAST_SHIFT_EN to replace the bit-serial shifter with a one-cycle barrel shifter.
module alu_iter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      aluctrl_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_e;
`endif

    state_e            state_q, state_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              ill_q, ill_d;
    logic [XLEN-1:0]   alu_res;
    logic              alu_ill;
    logic              accept;
    logic [SHW-1:0]    shamt;

    assign shamt = op_b_i[SHW-1:0];

`ifndef ALU_FAST_SHIFT_EN
    // res_q doubles as the working register while shifting.
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              left_q, left_d;
    logic              arith_q, arith_d;
    logic              is_shift;
    logic [XLEN-1:0]   step_res;

    assign step_res = left_q ? {res_q[XLEN-2:0], 1'b0}
                             : {arith_q & res_q[XLEN-1], res_q[XLEN-1:1]};
`endif

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
        is_shift = 1'b0;
`endif
        case (aluctrl_i)
            OP_ADD:  alu_res = op_a_i + op_b_i;
            OP_SUB:  alu_res = op_a_i - op_b_i;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
            OP_XOR:  alu_res = op_a_i ^ op_b_i;
            OP_OR:   alu_res = op_a_i | op_b_i;
            OP_AND:  alu_res = op_a_i & op_b_i;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  alu_res = op_a_i << shamt;
            OP_SRL:  alu_res = op_a_i >> shamt;
            OP_SRA:  alu_res = $signed(op_a_i) >>> shamt;
`else
            // A zero shift completes immediately with operand A unchanged.
            OP_SLL, OP_SRL, OP_SRA: begin
                is_shift = 1'b1;
                alu_res  = op_a_i;
            end
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = res_q;
    assign zero_o      = out_valid_o && (res_q == '0);
    assign illegal_o   = ill_q;

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ill_d   = ill_q;
`ifndef ALU_FAST_SHIFT_EN
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_DONE) && out_ready_i) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    res_d   = alu_res;
                    ill_d   = alu_ill;
                    state_d = S_DONE;
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        cnt_d   = shamt;
                        left_d  = (aluctrl_i == OP_SLL);
                        arith_d = aluctrl_i[3];
                        state_d = S_SHIFT;
                    end
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            S_SHIFT: begin
                res_d = step_res;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            ill_q   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
`ifndef ALU_FAST_SHIFT_EN
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
`endif
        end
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Execution-side consumer of the 4-bit ALU control code (encoding {funct7[5], funct3}).
- Registers operands and the op code.
- Single-cycle ops complete in one cycle; shifts run iteratively, one bit per cycle.
- Results are returned over a valid/ready handshake to the EX/writeback stage.

Parameters:
- XLEN, 32, operand/result width.
- SHW, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- in_valid_i  input  1  operands and op presented.
- in_ready_o  output  1  block can accept a new op.
- aluctrl_i  input  4  op code, as produced by the ALU control decoder.
- op_a_i  input  XLEN  operand A (rs1).
- op_b_i  input  XLEN  operand B (rs2/imm); bits [SHW-1:0] are the shamt for shifts.
- out_valid_o  output  1  result available.
- out_ready_i  input  1  consumer takes result.
- result_o  output  XLEN  result.
- zero_o  output  1  result_o == 0.
- illegal_o  output  1  op code was unassigned.

Behaviour:
- Op codes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011.
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - All other 6 codes are illegal.
- Arithmetic:
  - Modulo 2^XLEN; no overflow flag.
  - SLT is signed; SLTU is unsigned; both yield 0 or 1 zero-extended.
  - SRA replicates the sign bit; shamt = op_b_i[SHW-1:0], upper bits ignored.
- FSM states:
  - IDLE: in_ready_o=1. On accept (in_valid_i & in_ready_o):
    - Non-shift or illegal op: compute result, go to DONE.
    - Shift op with shamt=0: load result=op_a_i, go to DONE.
    - Shift op with shamt>0: load working reg=op_a_i and counter=shamt, go to SHIFT.
  - SHIFT: each cycle shift the working reg by 1 in the op's direction and decrement the counter. When the counter reaches 1, that final shift completes and the FSM goes to DONE. in_ready_o=0.
  - DONE: out_valid_o=1. result_o, zero_o and illegal_o are held stable until out_ready_i=1.
    - out_ready_i=1 with no new accept: go to IDLE.
    - in_ready_o = out_ready_i (combinational), allowing back-to-back issue.
    - Simultaneous drain and accept is legal: a new op is loaded in the same edge, exactly as from IDLE.
- Latency from accept edge to out_valid_o:
  - Non-shift ops: 1 cycle.
  - Shifts: 1+shamt cycles, max 32.
- Illegal op:
  - result_o=0, zero_o=1, illegal_o=1, latency 1.
  - No other side effect.
- Inputs are sampled only on the accept edge; later changes are ignored.
- Reset (any time, including mid-SHIFT):
  - State returns to IDLE; in-flight op is discarded.
  - in_ready_o=1, out_valid_o=0, result_o=0, zero_o=0, illegal_o=0.
  - Internal counter and working register cleared.
- No X propagation: undefined op codes never drive X onto outputs.

Optional Feature:
- ALU_FAST_SHIFT_EN
- Defined:
  - Shifts use a combinational barrel shifter and complete in 1 cycle, like other ops.
  - SHIFT state and counter are removed.
- Undefined: iterative shifter as above, with latency 1+shamt.
- Results are bit-identical in both builds.

Test Plan:
- ADD: op_a=0x7FFFFFFF, op_b=1 → result 0x80000000, zero=0, out_valid 1 cycle after accept.
- SUB: op_a=op_b=0x1234 → result 0, zero=1.
- SLT vs SLTU: op_a=0xFFFFFFFF, op_b=1 → SLT gives 1, SLTU gives 0.
- SRA: op_a=0x80000000, op_b=0x1F → result 0xFFFFFFFF, out_valid 32 cycles after accept. SRL with the same operands → 0x00000001. Shamt=0 → result=op_a after 1 cycle. With ALU_FAST_SHIFT_EN, latency is 1 in all cases.
- Backpressure and back-to-back:
  - Hold out_ready_i=0 for 5 cycles: result and flags stay stable; in_ready_o=0.
  - Then assert out_ready_i with in_valid_i (AND 0xF0F0&0xFF00): both complete on the same edge; next result 0xF000.
- Illegal code 1010 → illegal=1, result 0, zero=1. Assert rst_ni=0 mid-SLL (shamt=10, cycle 4): outputs go to reset values immediately; after release, in_ready_o=1 and no stale out_valid_o.
